env_ctrl_multi: RTL

Parametrised successor to the cold-storage logic controller. It periodically requests a sensor sample and latches N_CH 8-bit channel values. It evaluates one hysteresis actuator per channel (auto, force-off or force-on), then requests a UART metrics report. Thresholds and modes are programmed at runtime by 4-byte ASCII commands from the UART receiver. It sits between the sensor front-end, UART RX/TX and the LCD/LED outputs.

---
 rtl/env_ctrl_multi_pkg.sv | 47 ++++
 rtl/env_ctrl_multi_if.sv | 37 +++
 rtl/env_cmd_decode.sv | 54 +++++
 rtl/env_ctrl_multi.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/env_ctrl_multi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : env_ctrl_multi_pkg                                           |
// | Description : Shared FSM states, mode codes, ASCII command constants and    |
// |               the decoded-command record for the environment controller.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package env_ctrl_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_EVAL   = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_AUTO      = 2'd0,
    MODE_FORCE_OFF = 2'd1,
    MODE_FORCE_ON  = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_HI   = 2'd1,
    OP_LO   = 2'd2,
    OP_MODE = 2'd3
  } op_t;

  localparam logic [7:0] c_ascii_h = 8'h48;
  localparam logic [7:0] c_ascii_l = 8'h4C;
  localparam logic [7:0] c_ascii_m = 8'h4D;
  localparam logic [7:0] c_ascii_0 = 8'h30;

  typedef struct packed {
    op_t        op;
    logic [2:0] ch;
    logic [7:0] value;
    logic       err;
  } cmd_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

endpackage
`default_nettype wire

// File: rtl/env_ctrl_multi_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : env_ctrl_multi_if                                            |
// | Description : Sensor, UART and display/actuator signals of the controller. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface env_ctrl_multi_if #(
  parameter int N_CH = 2
);
  logic                 sense_req;
  logic                 sense_ready;
  logic [N_CH*8-1:0]    sample_vals;
  logic                 rx_valid;
  logic [7:0]           rx_cmd;
  logic [7:0]           rx_ch;
  logic [7:0]           rx_val0;
  logic [7:0]           rx_val1;
  logic                 tx_req;
  logic                 tx_done;
  logic [N_CH*8-1:0]    snapshot;
  logic                 frame_valid;
  logic [N_CH-1:0]      act;
  logic [1:0]           fault;
  logic                 cmd_err;

  // master is the controller; slave is the surrounding sensor/UART/display side
  modport master (
    output sense_req, tx_req, snapshot, frame_valid, act, fault, cmd_err,
    input  sense_ready, sample_vals, rx_valid, rx_cmd, rx_ch, rx_val0, rx_val1, tx_done
  );

  modport slave (
    input  sense_req, tx_req, snapshot, frame_valid, act, fault, cmd_err,
    output sense_ready, sample_vals, rx_valid, rx_cmd, rx_ch, rx_val0, rx_val1, tx_done
  );
endinterface
`default_nettype wire

// File: rtl/env_cmd_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : env_cmd_decode                                               |
// | Description : Combinational decode of a 4-byte ASCII command into          |
// |               {op, ch, value, err}; range checks against live thresholds   |
// |               are done by the owner of the threshold registers.            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module env_cmd_decode
  import env_ctrl_multi_pkg::*;
#(
  parameter int N_CH = 2
) (
  input  logic [7:0] i_cmd,
  input  logic [7:0] i_ch,
  input  logic [7:0] i_val0,
  input  logic [7:0] i_val1,
  output cmd_t       o_dec
);

  logic [7:0] w_d0;
  logic [7:0] w_d1;
  logic       w_ch_ok;
  logic       w_dig0;
  logic       w_dig1;

  assign w_d0    = i_val0 - c_ascii_0;
  assign w_d1    = i_val1 - c_ascii_0;
  assign w_ch_ok = (i_ch >= c_ascii_0) && (i_ch < (c_ascii_0 + 8'(N_CH)));
  assign w_dig0  = is_digit(i_val0);
  assign w_dig1  = is_digit(i_val1);

  always_comb begin
    o_dec.op    = OP_NONE;
    o_dec.ch    = i_ch[2:0];  // '0'..'7' carry the index in their low bits
    o_dec.value = 8'd0;
    o_dec.err   = 1'b1;
    case (i_cmd)
      c_ascii_h, c_ascii_l: begin
        o_dec.op    = (i_cmd == c_ascii_h) ? OP_HI : OP_LO;
        o_dec.value = 8'(w_d0 * 8'd10) + w_d1;
        o_dec.err   = !(w_ch_ok && w_dig0 && w_dig1);
      end
      c_ascii_m: begin
        o_dec.op    = OP_MODE;
        o_dec.value = w_d1;
        o_dec.err   = !(w_ch_ok && w_dig1 && (w_d1 <= 8'd2));
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/env_ctrl_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : env_ctrl_multi                                               |
// | Description : Periodic sample / per-channel hysteresis / UART report       |
// |               controller with runtime-programmable thresholds and modes.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module env_ctrl_multi
  import env_ctrl_multi_pkg::*;
#(
  parameter int                N_CH     = 2,
  parameter int                INTERVAL = 1_000_000,
  parameter int                TIMEOUT  = 50_000,
  parameter logic [N_CH-1:0]   POLARITY = 2'b01,
  parameter logic [N_CH*8-1:0] DEF_LO   = {8'd10, 8'd0},
  parameter logic [N_CH*8-1:0] DEF_HI   = {8'd35, 8'd18}
) (
  input  logic              clk,
  input  logic              rst_n,
  env_ctrl_multi_if.master  bus
);

  localparam logic [31:0] c_interval_m1 = 32'(INTERVAL - 1);
  localparam logic [31:0] c_timeout_m1  = 32'(TIMEOUT - 1);
  localparam logic [2:0]  c_last_idx    = 3'(N_CH - 1);

  state_t            r_state;
  logic [31:0]       r_int_cnt;
  logic [31:0]       r_to_cnt;
  logic [2:0]        r_idx;
  logic              r_sense_req;
  logic              r_tx_req;
  logic              r_frame_valid;
  logic              r_cmd_err;
  logic [1:0]        r_fault;
  logic [N_CH*8-1:0] r_snapshot;
  logic [N_CH-1:0]   w_act;
  logic [N_CH-1:0]   w_range_err;
  cmd_t              w_dec;

  env_cmd_decode #(
    .N_CH (N_CH)
  ) u_dec (
    .i_cmd  (bus.rx_cmd),
    .i_ch   (bus.rx_ch),
    .i_val0 (bus.rx_val0),
    .i_val1 (bus.rx_val1),
    .o_dec  (w_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_int_cnt     <= 32'd0;
      r_to_cnt      <= 32'd0;
      r_idx         <= 3'd0;
      r_sense_req   <= 1'b0;
      r_tx_req      <= 1'b0;
      r_frame_valid <= 1'b0;
      r_fault       <= 2'b00;
      r_snapshot    <= '0;
    end else begin
      r_frame_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_int_cnt == c_interval_m1) begin
            r_state     <= ST_REQ;
            r_sense_req <= 1'b1;
            r_to_cnt    <= 32'd0;
          end else begin
            r_int_cnt <= r_int_cnt + 32'd1;
          end
        end
        ST_REQ: begin
          if (bus.sense_ready) begin
            r_snapshot  <= bus.sample_vals;
            r_fault[0]  <= 1'b0;
            r_sense_req <= 1'b0;
            r_idx       <= 3'd0;
            r_state     <= ST_EVAL;
          end else if (r_to_cnt == c_timeout_m1) begin
            // Sensor gave up: skip evaluation, keep last snapshot and actuators
            r_fault[0]    <= 1'b1;
            r_sense_req   <= 1'b0;
            r_tx_req      <= 1'b1;
            r_frame_valid <= 1'b1;
            r_to_cnt      <= 32'd0;
            r_state       <= ST_REPORT;
          end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
          end
        end
        ST_EVAL: begin
          if (r_idx == c_last_idx) begin
            r_tx_req      <= 1'b1;
            r_frame_valid <= 1'b1;
            r_to_cnt      <= 32'd0;
            r_state       <= ST_REPORT;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        ST_REPORT: begin
          if (bus.tx_done) begin
            r_fault[1] <= 1'b0;
            r_tx_req   <= 1'b0;
            r_int_cnt  <= 32'd0;
            r_state    <= ST_IDLE;
          end else if (r_to_cnt == c_timeout_m1) begin
            r_fault[1] <= 1'b1;
            r_tx_req   <= 1'b0;
            r_int_cnt  <= 32'd0;
            r_state    <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_err <= 1'b0;
    end else begin
      r_cmd_err <= bus.rx_valid && (w_dec.err || (|w_range_err));
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [7:0] r_lo;
    logic [7:0] r_hi;
    logic [1:0] r_mode;
    logic       r_act;
    logic [7:0] w_val;
    logic [1:0] w_mode_nxt;
    logic       w_sel;
    logic       w_wr_hi;
    logic       w_wr_lo;
    logic       w_eval;

    assign w_val   = r_snapshot[8*i +: 8];
    assign w_sel   = bus.rx_valid && !w_dec.err && (w_dec.ch == 3'(i));
    assign w_wr_hi = w_sel && (w_dec.op == OP_HI) && (w_dec.value >= r_lo);
    assign w_wr_lo = w_sel && (w_dec.op == OP_LO) && (w_dec.value <= r_hi);
    assign w_range_err[i] = w_sel &&
                            (((w_dec.op == OP_HI) && (w_dec.value < r_lo)) ||
                             ((w_dec.op == OP_LO) && (w_dec.value > r_hi)));
    // Forced modes take effect on the same edge that stores the new mode
    assign w_mode_nxt = (w_sel && (w_dec.op == OP_MODE)) ? w_dec.value[1:0] : r_mode;
    assign w_eval     = (r_state == ST_EVAL) && (r_idx == 3'(i));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_lo   <= DEF_LO[8*i +: 8];
        r_hi   <= DEF_HI[8*i +: 8];
        r_mode <= MODE_AUTO;
        r_act  <= 1'b0;
      end else begin
        if (w_wr_hi) r_hi <= w_dec.value;
        if (w_wr_lo) r_lo <= w_dec.value;
        r_mode <= w_mode_nxt;
        if (w_mode_nxt == MODE_FORCE_OFF) begin
          r_act <= 1'b0;
        end else if (w_mode_nxt == MODE_FORCE_ON) begin
          r_act <= 1'b1;
        end else if (w_eval) begin
          if (POLARITY[i]) begin
            if (w_val > r_hi)      r_act <= 1'b1;
            else if (w_val < r_lo) r_act <= 1'b0;
          end else begin
            if (w_val < r_lo)      r_act <= 1'b1;
            else if (w_val > r_hi) r_act <= 1'b0;
          end
        end
      end
    end

    assign w_act[i] = r_act;
  end : g_ch

  assign bus.sense_req   = r_sense_req;
  assign bus.tx_req      = r_tx_req;
  assign bus.snapshot    = r_snapshot;
  assign bus.frame_valid = r_frame_valid;
  assign bus.act         = w_act;
  assign bus.fault       = r_fault;
  assign bus.cmd_err     = r_cmd_err;

endmodule
`default_nettype wire
